// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state codes,
// timeout defaults and the enabled 3-to-8 grant decoder.
package rr_arbiter_8_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_GRANT = 2'b01;
   localparam logic [1:0] ST_TURN  = 2'b10;

   localparam int unsigned TMO_W_DEF   = 4;
   localparam int unsigned TMO_MAX_DEF = 15;

   function automatic logic [7:0] dec3to8_en(input logic [2:0] sel, input logic en);
      logic [7:0] onehot;
      onehot = '0;
      if (en)
         onehot[sel] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/rr_arbiter_8_scan.sv
// Round-robin priority scan: rotate req so ptr sits at bit 0, take the
// lowest set bit, then add ptr back (mod 8) to recover the real index.
module rr_priority_scan (
   input  logic [7:0] req,
   input  logic [2:0] ptr,
   output logic [2:0] idx,
   output logic       any
);

   logic [7:0] rot;
   logic [2:0] pick;
   logic       found;

   always_comb begin
      rot   = 8'({req, req} >> ptr);
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (rot[i] && !found) begin
            pick  = 3'(i);
            found = 1'b1;
         end
      end
      idx = pick + ptr;
      any = |req;
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold timeout and a
// one-cycle turnaround between grants.
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int unsigned TMO_W   = TMO_W_DEF,
   parameter int unsigned TMO_MAX = TMO_MAX_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       busy,
   output logic       timeout
);

   localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO_MAX - 1);

   logic [1:0]       state;
   logic [2:0]       ptr;
   logic [TMO_W-1:0] cnt;
   logic [2:0]       scan_idx;
   logic             scan_any;

   rr_priority_scan u_scan (
      .req (req),
      .ptr (ptr),
      .idx (scan_idx),
      .any (scan_any)
   );

   // Grant is decoded straight from state so an async reset clears it at once.
   assign busy  = (state == ST_GRANT);
   assign grant = dec3to8_en(grant_idx, busy);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         grant_idx <= '0;
         ptr       <= '0;
         cnt       <= '0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (scan_any) begin
                  state     <= ST_GRANT;
                  grant_idx <= scan_idx;
                  cnt       <= '0;
               end
            end
            ST_GRANT: begin
               // done takes precedence so a simultaneous release is not flagged as a timeout
               if (done) begin
                  state <= ST_TURN;
                  ptr   <= grant_idx + 3'd1;
               end else if (cnt == CNT_LAST) begin
                  state   <= ST_TURN;
                  ptr     <= grant_idx + 3'd1;
                  timeout <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_TURN: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (built with TMO_MAX=4).
module tb_rr_arbiter_8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] req   = '0;
   logic       done  = 1'b0;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       busy;
   logic       timeout;

   int unsigned checks = 0;
   int unsigned errors = 0;

   rr_arbiter_8 #(.TMO_W(4), .TMO_MAX(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .done      (done),
      .grant     (grant),
      .grant_idx (grant_idx),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      done  = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_g;

      // reset state
      step();
      check("rst_grant", 32'(grant), 32'h00);
      check("rst_idx", 32'(grant_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tmo", 32'(timeout), 32'd0);
      reset = 1'b0;

      // single request, done release, ptr becomes 3
      req = 8'b0000_0100;
      step();
      check("t1_grant", 32'(grant), 32'h04);
      check("t1_idx", 32'(grant_idx), 32'd2);
      check("t1_busy", 32'(busy), 32'd1);
      done = 1'b1;
      step();
      check("t1_turn_grant", 32'(grant), 32'h00);
      check("t1_turn_busy", 32'(busy), 32'd0);
      check("t1_turn_idx", 32'(grant_idx), 32'd2);
      check("t1_turn_tmo", 32'(timeout), 32'd0);
      done = 1'b0;
      req  = 8'h09;
      step();
      check("t1_idle_busy", 32'(busy), 32'd0);
      step();
      check("t1_ptr3_idx", 32'(grant_idx), 32'd3);
      check("t1_ptr3_grant", 32'(grant), 32'h08);
      done = 1'b1;
      step();
      done = 1'b0;
      req  = '0;
      step();

      // all requesting: rotation 0..7 then wrap to 0
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         exp_g = 8'h01 << (k % 8);
         step();
         check("rr_grant", 32'(grant), 32'(exp_g));
         check("rr_busy", 32'(busy), 32'd1);
         done = 1'b1;
         step();
         check("rr_turn", 32'(grant), 32'h00);
         done = 1'b0;
         step();
         check("rr_idle", 32'(busy), 32'd0);
      end

      // ptr=5 after owner 4: scan 5,6,7,0 picks 0
      do_reset();
      req = 8'h10;
      step();
      check("p5_first", 32'(grant_idx), 32'd4);
      done = 1'b1;
      req  = 8'h11;
      step();
      done = 1'b0;
      step();
      step();
      check("p5_idx", 32'(grant_idx), 32'd0);
      check("p5_grant", 32'(grant), 32'h01);
      done = 1'b1;
      step();
      done = 1'b0;
      req  = '0;
      step();

      // hold timeout: 4 grant cycles then one-cycle timeout pulse
      do_reset();
      req = 8'h08;
      for (int c = 0; c < 4; c++) begin
         step();
         check("tmo_hold", 32'(grant), 32'h08);
         check("tmo_nopulse", 32'(timeout), 32'd0);
      end
      step();
      check("tmo_pulse", 32'(timeout), 32'd1);
      check("tmo_turn_grant", 32'(grant), 32'h00);
      step();
      check("tmo_pulse_end", 32'(timeout), 32'd0);
      check("tmo_idle_grant", 32'(grant), 32'h00);
      step();
      check("tmo_regrant", 32'(grant), 32'h08);

      // done coinciding with the last allowed cycle wins over timeout
      step();
      step();
      step();
      check("both_still", 32'(grant), 32'h08);
      done = 1'b1;
      step();
      check("both_tmo", 32'(timeout), 32'd0);
      check("both_busy", 32'(busy), 32'd0);
      done = 1'b0;
      req  = '0;
      step();

      // asynchronous reset mid-grant
      do_reset();
      req = 8'h20;
      step();
      check("ar_grant", 32'(grant), 32'h20);
      reset = 1'b1;
      #1;
      check("ar_grant0", 32'(grant), 32'h00);
      check("ar_busy0", 32'(busy), 32'd0);
      check("ar_idx0", 32'(grant_idx), 32'd0);
      #1;
      reset = 1'b0;
      req   = 8'h21;
      step();
      check("ar_after", 32'(grant), 32'h01);
      check("ar_after_idx", 32'(grant_idx), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
